// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph table, blank code and
// digit count, plus small helpers used by the display scanners.
package seg7_pkg;

    localparam int         DIGITS    = 8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low glyphs, bit 7 = dp (off), bits 6:0 = g..a. Entry n is the
    // glyph for hex value n (entry 0 is the rightmost byte).
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // One copy of everything needed to render a full frame.
    typedef struct packed {
        logic [31:0] nib;   // digit i = nib[4i+3:4i]
        logic [7:0]  dot;   // decimal point request per digit
        logic [7:0]  den;   // 0 blanks the digit
    } disp_t;

    // Active-high one-hot digit select.
    function automatic logic [7:0] sel_onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder (active-low g..a).
// Shared by every display block that needs a glyph.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // dp is handled by the caller, so only the g..a bits are exported.
    assign seg_o = SEG_TABLE[hex_i][6:0];

endmodule

// File: rtl/hex8_scan.sv
// Eight-digit multiplexed scanner: holds a displayed copy of the digits,
// steps through them at a fixed dwell and emits one {segments, select}
// word per dwell with a single-cycle strobe for the HC595 driver.
// New data is only adopted at the start of a frame so a frame never shows
// a mix of two updates.
module hex8_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_data,
    input  logic [7:0]  dot_en,
    input  logic [7:0]  digit_en,
    input  logic        update,
    output logic [15:0] data,
    output logic        en
);

    localparam int             CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  TC = CW'(SCAN_DIV - 1);

    // The driver needs 136 cycles to shift a word out; a shorter dwell
    // would overwrite a word mid-shift.
    generate
        if (SCAN_DIV < 136) begin : g_cfg_err
            $error("hex8_scan: SCAN_DIV=%0d is below the minimum of 136", SCAN_DIV);
        end
    endgenerate

    logic [CW-1:0] div_cnt_q;
    logic [2:0]    cur_idx_q;
    disp_t         pend_q;
    logic          pend_vld_q;
    disp_t         shad_q;
    logic [15:0]   data_q;
    logic          en_q;

    disp_t         in_w;
    disp_t         shad_d;
    logic [2:0]    idx_d;
    logic          tc;
    logic          frame;
    logic [3:0]    nib_w;
    logic [6:0]    glyph_w;
    logic [7:0]    seg_w;
    logic [15:0]   word_d;

    assign in_w = '{nib: disp_data, dot: dot_en, den: digit_en};

    // Terminal count, next index and frame-boundary detection.
    always_comb begin
        tc    = (div_cnt_q == TC);
        idx_d = cur_idx_q + 3'd1;
        frame = tc && (idx_d == 3'd0);
    end

    // Next shadow: a same-cycle update beats an older pending copy, so the
    // digit-0 word can already show data strobed in on the boundary cycle.
    always_comb begin
        shad_d = shad_q;
        if (frame) begin
            if (update)
                shad_d = in_w;
            else if (pend_vld_q)
                shad_d = pend_q;
        end
    end

    assign nib_w = shad_d.nib[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex_i (nib_w),
        .seg_o (glyph_w)
    );

    // Word for the digit that becomes current on this terminal count.
    always_comb begin
        seg_w  = shad_d.den[idx_d] ? {~shad_d.dot[idx_d], glyph_w} : SEG_BLANK;
        word_d = {seg_w, sel_onehot(idx_d)};
    end

    // Dwell divider and digit index; index starts at 7 so the first word
    // after reset is digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            cur_idx_q <= 3'd7;
        end else if (tc) begin
            div_cnt_q <= '0;
            cur_idx_q <= idx_d;
        end else begin
            div_cnt_q <= div_cnt_q + CW'(1);
        end
    end

    // Pending copy of the inputs; consumed at the next frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            if (update)
                pend_q <= in_w;
            if (frame)
                pend_vld_q <= 1'b0;
            else if (update)
                pend_vld_q <= 1'b1;
        end
    end

    // Displayed copy, only changes on a frame boundary.
    always_ff @(posedge clk) begin
        if (rst)
            shad_q <= '0;
        else
            shad_q <= shad_d;
    end

    // Registered output word and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {SEG_BLANK, 8'h00};
            en_q   <= 1'b0;
        end else begin
            en_q <= tc;
            if (tc)
                data_q <= word_d;
        end
    end

    assign data = data_q;
    assign en   = en_q;

endmodule
